// File: rtl/store_trace_checker_pkg.sv
// Shared types for the store trace checker: FSM state and verdict codes.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package store_trace_checker_pkg;

   // Run-controller states; IDLE and DONE are the only states that accept
   // table writes and a new start.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RST  = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Verdict codes presented on fail_code.
   typedef enum logic [1:0] {
      FAIL_NONE     = 2'd0,
      FAIL_MISMATCH = 2'd1,
      FAIL_TIMEOUT  = 2'd2,
      FAIL_EXTRA    = 2'd3
   } fail_t;

endpackage

// File: rtl/store_trace_checker_exp_table.sv
// Expected-store table: DEPTH x W register file, one sync write, one async read.
// Latency: write visible on read port the cycle after the write edge; read is combinational.
// Backpressure: none; every write is accepted.
//
// Ports: clk; we/widx/wdat write port; ridx/rdat asynchronous read port.
// Contents are deliberately not reset; they are undefined until written.
module store_trace_checker_exp_table #(
   parameter int DEPTH = 8,
   parameter int IW    = 3,
   parameter int W     = 64
) (
   input  logic          clk,
   input  logic          we,
   input  logic [IW-1:0] widx,
   input  logic [W-1:0]  wdat,
   input  logic [IW-1:0] ridx,
   output logic [W-1:0]  rdat
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[widx] <= wdat;
      end
   end

   assign rdat = mem[ridx];

endmodule

// File: rtl/store_trace_checker.sv
// Run controller: holds the CPU in reset, then checks each CPU store in order against a loaded table.
// Latency: verdict (done/pass/fail_*) registered on the deciding edge; cpu_reset tracks state directly.
// Backpressure: none; every CPU store is evaluated the cycle it is presented, nothing is stalled.
//
// Ports: clk, reset (async, active-low); start/n_exp run control; exp_we/exp_idx/exp_addr/exp_data
// table load; memwrite/dataadr/writedata CPU store snoop; cpu_reset to CPU; done/pass/fail_code/
// fail_idx/match_cnt/cycle_cnt verdict and progress.
module store_trace_checker
   import store_trace_checker_pkg::*;
#(
   parameter int DW         = 32,
   parameter int AW         = 32,
   parameter int DEPTH      = 8,
   parameter int RST_CYCLES = 2,
   parameter int TIMEOUT    = 100,
   parameter int CW         = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [$clog2(DEPTH):0]     n_exp,
   input  logic                       exp_we,
   input  logic [$clog2(DEPTH)-1:0]   exp_idx,
   input  logic [AW-1:0]              exp_addr,
   input  logic [DW-1:0]              exp_data,
   input  logic                       memwrite,
   input  logic [AW-1:0]              dataadr,
   input  logic [DW-1:0]              writedata,
   output logic                       cpu_reset,
   output logic                       done,
   output logic                       pass,
   output logic [1:0]                 fail_code,
   output logic [$clog2(DEPTH)-1:0]   fail_idx,
   output logic [$clog2(DEPTH):0]     match_cnt,
   output logic [CW-1:0]              cycle_cnt
);

   localparam int IW  = $clog2(DEPTH);
   localparam int NW  = IW + 1;
   localparam int RCW = $clog2(RST_CYCLES + 1);

   state_t           state_q, state_d;
   logic [RCW-1:0]   rst_cnt_q;
   logic [NW-1:0]    n_exp_q;
   logic [NW-1:0]    match_q;
   logic [CW-1:0]    cycle_q;
   logic             done_q, pass_q;
   fail_t            fail_q;
   logic [IW-1:0]    fidx_q;

   // control decoded by the FSM for the datapath registers
   logic             go, rst_inc, run_tick, m_inc, fin, fin_pass;
   fail_t            fin_code;
   logic [IW-1:0]    fin_idx;
   logic [NW-1:0]    match_next;

   logic [NW-1:0]    n_exp_clamp;
   logic             tbl_we;
   logic [AW+DW-1:0] tbl_rd;
   logic             hit;

   // Requests above DEPTH would otherwise chase table entries that do not exist.
   assign n_exp_clamp = (n_exp > NW'(DEPTH)) ? NW'(DEPTH) : n_exp;

   assign tbl_we = exp_we && ((state_q == S_IDLE) || (state_q == S_DONE));

   store_trace_checker_exp_table #(
      .DEPTH (DEPTH),
      .IW    (IW),
      .W     (AW + DW)
   ) u_exp_table (
      .clk  (clk),
      .we   (tbl_we),
      .widx (exp_idx),
      .wdat ({exp_addr, exp_data}),
      .ridx (match_q[IW-1:0]),
      .rdat (tbl_rd)
   );

   assign hit = (tbl_rd == {dataadr, writedata});

   // ------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------
   // FSM next-state and datapath control
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      go         = 1'b0;
      rst_inc    = 1'b0;
      run_tick   = 1'b0;
      m_inc      = 1'b0;
      fin        = 1'b0;
      fin_pass   = 1'b0;
      fin_code   = FAIL_NONE;
      fin_idx    = '0;
      match_next = match_q;

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_RST;
               go      = 1'b1;
            end
         end

         S_RST: begin
            if (rst_cnt_q == RCW'(RST_CYCLES - 1)) begin
               state_d = S_RUN;
            end else begin
               rst_inc = 1'b1;
            end
         end

         S_RUN: begin
            run_tick = 1'b1;
            // The store is judged before the timeout so a completing store
            // on the last budget cycle still passes.
            if (memwrite) begin
               if (match_q < n_exp_q) begin
                  if (hit) begin
                     m_inc = 1'b1;
                     if (match_q == (n_exp_q - NW'(1))) begin
                        fin      = 1'b1;
                        fin_pass = 1'b1;
                     end
                  end else begin
                     fin      = 1'b1;
                     fin_code = FAIL_MISMATCH;
                     fin_idx  = match_q[IW-1:0];
                  end
               end else begin
                  fin      = 1'b1;
                  fin_code = FAIL_EXTRA;
               end
            end

            match_next = match_q + NW'(m_inc);

            if (!fin && (cycle_q == CW'(TIMEOUT - 1))) begin
               fin = 1'b1;
               if (n_exp_q == '0) begin
                  fin_pass = 1'b1;
               end else begin
                  // Point at the entry still being waited for.
                  fin_code = FAIL_TIMEOUT;
                  fin_idx  = match_next[IW-1:0];
               end
            end

            if (fin) begin
               state_d = S_DONE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Counters, pointer and registered verdict
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_cnt_q <= '0;
         n_exp_q   <= '0;
         match_q   <= '0;
         cycle_q   <= '0;
         done_q    <= 1'b0;
         pass_q    <= 1'b0;
         fail_q    <= FAIL_NONE;
         fidx_q    <= '0;
      end else begin
         if (go) begin
            rst_cnt_q <= '0;
            n_exp_q   <= n_exp_clamp;
            match_q   <= '0;
            cycle_q   <= '0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fail_q    <= FAIL_NONE;
            fidx_q    <= '0;
         end else begin
            if (rst_inc) begin
               rst_cnt_q <= rst_cnt_q + RCW'(1);
            end
            if (run_tick) begin
               cycle_q <= cycle_q + CW'(1);
            end
            if (m_inc) begin
               match_q <= match_q + NW'(1);
            end
            if (fin) begin
               done_q <= 1'b1;
               pass_q <= fin_pass;
               fail_q <= fin_code;
               fidx_q <= fin_idx;
            end
         end
      end
   end

   assign cpu_reset = (state_q != S_RUN);
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_code = fail_q;
   assign fail_idx  = fidx_q;
   assign match_cnt = match_q;
   assign cycle_cnt = cycle_q;

endmodule

// File: tb/tb_store_trace_checker.sv
// Bench for store_trace_checker: directed runs, expected verdicts queued at issue time and
// compared by an independent monitor whenever done rises.
module tb_store_trace_checker;

   localparam int DW = 32, AW = 32, DEPTH = 8, RST_CYCLES = 2, TIMEOUT = 100, CW = 16;
   localparam int IW = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [IW:0]       n_exp = '0;
   logic              exp_we = 1'b0;
   logic [IW-1:0]     exp_idx = '0;
   logic [AW-1:0]     exp_addr = '0;
   logic [DW-1:0]     exp_data = '0;
   logic              memwrite = 1'b0;
   logic [AW-1:0]     dataadr = '0;
   logic [DW-1:0]     writedata = '0;
   logic              cpu_reset, done, pass;
   logic [1:0]        fail_code;
   logic [IW-1:0]     fail_idx;
   logic [IW:0]       match_cnt;
   logic [CW-1:0]     cycle_cnt;

   store_trace_checker #(
      .DW(DW), .AW(AW), .DEPTH(DEPTH), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT), .CW(CW)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .n_exp(n_exp),
      .exp_we(exp_we), .exp_idx(exp_idx), .exp_addr(exp_addr), .exp_data(exp_data),
      .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
      .cpu_reset(cpu_reset), .done(done), .pass(pass), .fail_code(fail_code),
      .fail_idx(fail_idx), .match_cnt(match_cnt), .cycle_cnt(cycle_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        p;
      logic [1:0]  fc;
      logic [2:0]  fi;
      logic [3:0]  mc;
      logic [15:0] cc;
   } verdict_t;

   verdict_t exp_q[$];
   verdict_t mv;
   int n_cmp = 0;
   int n_err = 0;
   int rc = 0;          // current RUN cycle, 1-based
   logic done_prev = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, expv);
      end
   endtask

   task automatic expect_v(input logic p, input int fc, input int fi, input int mc, input int cc);
      verdict_t v;
      v.p  = p;
      v.fc = 2'(fc);
      v.fi = 3'(fi);
      v.mc = 4'(mc);
      v.cc = 16'(cc);
      exp_q.push_back(v);
   endtask

   // Monitor: one verdict per rising done, checked against the oldest queued expectation.
   always @(negedge clk) begin
      if (done && !done_prev) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_verdict: got done with pass=%0d code=%0d, expected none", pass, fail_code);
         end else begin
            mv = exp_q.pop_front();
            chk("v_pass", 32'(pass), 32'(mv.p));
            chk("v_fail_code", 32'(fail_code), 32'(mv.fc));
            chk("v_fail_idx", 32'(fail_idx), 32'(mv.fi));
            chk("v_match_cnt", 32'(match_cnt), 32'(mv.mc));
            chk("v_cycle_cnt", 32'(cycle_cnt), 32'(mv.cc));
            chk("v_cpu_reset", 32'(cpu_reset), 32'd1);
         end
      end
      done_prev = done;
   end

   task automatic load(input int idx, input int a, input int d);
      @(negedge clk);
      exp_we = 1'b1; exp_idx = IW'(idx); exp_addr = AW'(a); exp_data = DW'(d);
      @(negedge clk);
      exp_we = 1'b0;
   endtask

   // Pulses start, then measures how many cycles cpu_reset stays high before RUN.
   task automatic start_run(input int n);
      int cnt;
      @(negedge clk);
      start = 1'b1; n_exp = (IW+1)'(n);
      @(negedge clk);
      start = 1'b0;
      cnt = 0;
      while (cpu_reset && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("rst_hold_cycles", 32'(cnt), 32'(RST_CYCLES));
      rc = 1;
   endtask

   task automatic wait_to(input int n);
      while (rc < n) begin
         @(negedge clk);
         rc++;
      end
   endtask

   task automatic store(input int n, input int a, input int d);
      wait_to(n);
      memwrite = 1'b1; dataadr = AW'(a); writedata = DW'(d);
      @(negedge clk);
      rc++;
      memwrite = 1'b0;
   endtask

   task automatic pulse_start(input int n);
      wait_to(n);
      start = 1'b1; n_exp = '0;
      @(negedge clk);
      rc++;
      start = 1'b0;
   endtask

   task automatic wait_done();
      int k = 0;
      while (!done && k < 300) begin
         @(negedge clk);
         k++;
      end
      if (!done) begin
         n_cmp++;
         n_err++;
         $display("FAIL wait_done: got no done within 300 cycles, expected done");
      end
   endtask

   initial begin
      // reset state
      #3;
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_fail_code", 32'(fail_code), 32'd0);
      chk("rst_fail_idx", 32'(fail_idx), 32'd0);
      chk("rst_match_cnt", 32'(match_cnt), 32'd0);
      chk("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // single expected store, arrives at RUN cycle 17
      load(0, 84, 7);
      expect_v(1'b1, 0, 0, 1, 17);
      start_run(1);
      store(17, 84, 7);
      wait_done();

      // restart from DONE reuses table; a start during RUN must be ignored
      expect_v(1'b1, 0, 0, 1, 3);
      start_run(1);
      pulse_start(2);
      store(3, 84, 7);
      wait_done();

      // no store within the budget
      expect_v(1'b0, 2, 0, 0, 100);
      start_run(1);
      wait_done();

      // completing store on the timeout cycle passes
      expect_v(1'b1, 0, 0, 1, 100);
      start_run(1);
      store(100, 84, 7);
      wait_done();

      // second store has wrong data
      load(0, 80, 5);
      load(1, 84, 7);
      expect_v(1'b0, 1, 1, 1, 5);
      start_run(2);
      store(3, 80, 5);
      store(5, 84, 8);
      wait_done();

      // async reset mid-RUN: verdict discarded, outputs return to reset values at once
      start_run(2);
      store(3, 80, 5);
      wait_to(6);
      chk("mid_match_cnt", 32'(match_cnt), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("arst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_match_cnt", 32'(match_cnt), 32'd0);
      chk("arst_cycle_cnt", 32'(cycle_cnt), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // nothing expected, one store arrives
      expect_v(1'b0, 3, 0, 0, 4);
      start_run(0);
      store(4, 64, 1);
      wait_done();

      // nothing expected, nothing arrives
      expect_v(1'b1, 0, 0, 0, 100);
      start_run(0);
      wait_done();

      // n_exp above DEPTH clamps to DEPTH: eight matches complete the run
      for (int i = 0; i < DEPTH; i++) load(i, 256 + 4*i, 3*i + 1);
      expect_v(1'b1, 0, 0, 8, 8);
      start_run(15);
      for (int i = 0; i < DEPTH; i++) store(i + 1, 256 + 4*i, 3*i + 1);
      wait_done();

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
